// File: rtl/prime_capture_fifo_if.sv
// Handshake bundle between primenums, prime_capture_fifo and its reader.
// slave = capture FIFO side, master = the driver/reader side.
interface prime_capture_fifo_if;
  logic [9:0] NumberChecked;
  logic       Prime;
  logic       PrimeReady;
  logic [9:0] PrimeOut;
  logic       PrimeValid;

  modport master (
    output NumberChecked, Prime, PrimeReady,
    input  PrimeOut, PrimeValid
  );

  modport slave (
    input  NumberChecked, Prime, PrimeReady,
    output PrimeOut, PrimeValid
  );
endinterface

// File: rtl/prime_capture_fifo.sv
// Captures confirmed primes into a small FIFO and tracks gap statistics.
// Define PRIME_TWIN_COUNT_EN to add the TwinCount output.
module prime_capture_fifo #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int SETTLE = 2
) (
  input  logic          SysClk,
  input  logic          Reset,
  prime_capture_fifo_if.slave bus,
  output logic [AW:0]   Count,
  output logic          Full,
  output logic          Overflow,
  output logic [9:0]    LastPrime,
  output logic [9:0]    MaxGap
`ifdef PRIME_TWIN_COUNT_EN
  ,
  output logic [7:0]    TwinCount
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE
  } state_t;

  localparam logic [2:0]    SET  = 3'(SETTLE);
  localparam logic [AW:0]   DEP  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  state_t        state_q, state_d;
  logic [9:0]    cand_q, cand_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [9:0]    last_q, last_d;
  logic [9:0]    max_q, max_d;
  logic          have_q, have_d;
  logic [7:0]    twin_q, twin_d;

  logic          cap;
  logic          pop;
  logic          push;
  logic          full;
  logic          have_eff;
  logic [9:0]    gap;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.NumberChecked != cand_q) begin
          cand_d  = bus.NumberChecked;
          cnt_d   = SET;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.NumberChecked != cand_q) begin
          cand_d = bus.NumberChecked;
          cnt_d  = SET;
        end else if (cnt_q == 3'd1) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      SAMPLE: begin
        cap     = bus.Prime;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A candidate below the last prime means primenums started over.
  assign full     = (count_q == DEP);
  assign pop      = (count_q != '0) && bus.PrimeReady;
  assign push     = cap && (!full || pop);
  assign have_eff = have_q && !(cand_q < last_q);
  assign gap      = cand_q - last_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    max_d   = max_q;
    have_d  = have_q;
    twin_d  = twin_q;
    if (push) wr_d = wr_q + PONE;
    if (pop)  rd_d = rd_q + PONE;
    if (push && !pop) count_d = count_q + ONE;
    if (pop && !push) count_d = count_q - ONE;
    if (cap && full && !pop) ovf_d = 1'b1;
    if (cap) begin
      last_d = cand_q;
      have_d = 1'b1;
      if (have_eff && gap > max_q) max_d = gap;
      if (have_eff && gap == 10'd2 && twin_q != 8'hFF)
        twin_d = twin_q + 8'd1;
    end
  end

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
      max_q   <= '0;
      have_q  <= 1'b0;
      twin_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      max_q   <= max_d;
      have_q  <= have_d;
      twin_q  <= twin_d;
      if (push) mem_q[wr_q] <= cand_q;
    end
  end

  assign bus.PrimeOut   = mem_q[rd_q];
  assign bus.PrimeValid = (count_q != '0);
  assign Count          = count_q;
  assign Full           = full;
  assign Overflow       = ovf_q;
  assign LastPrime      = last_q;
  assign MaxGap         = max_q;

`ifdef PRIME_TWIN_COUNT_EN
  assign TwinCount = twin_q;
`else
  logic unused_twin;
  assign unused_twin = ^twin_q;
`endif

endmodule

// File: doc/prime_capture_fifo.md
Name: prime_capture_fifo

Overview:
- Downstream consumer of the primenums stage.
- Watches the NumberChecked/Prime stream and captures each confirmed prime into a small FIFO, drained by a valid/ready reader (display or UART stage).
- Tracks prime-gap statistics on the fly: last prime seen and largest gap between consecutive primes.
- Decouples primenums' fixed pacing from a slower, stalling consumer.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, 3, FIFO address width; log2(DEPTH).
- SETTLE, 2, cycles after a NumberChecked change before Prime is sampled; 1..7.

Ports:
- SysClk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- NumberChecked  in  10  candidate currently under test by primenums.
- Prime  in  1  primenums verdict for NumberChecked.
- PrimeReady  in  1  reader accepts PrimeOut this cycle.
- PrimeOut  out  10  FIFO head value.
- PrimeValid  out  1  FIFO non-empty; PrimeOut is meaningful.
- Count  out  AW+1  current FIFO occupancy.
- Full  out  1  Count == DEPTH.
- Overflow  out  1  sticky; a prime was dropped because the FIFO was full.
- LastPrime  out  10  most recent prime captured or dropped.
- MaxGap  out  10  largest difference between consecutive primes since restart.

Behaviour:
- Reset low, asynchronous, takes effect immediately:
  - Count=0, PrimeValid=0, Full=0, Overflow=0.
  - LastPrime=0, MaxGap=0, PrimeOut=0.
  - Internal "have-prev" flag cleared; state machine to IDLE.
  - Internal last-candidate register = 0.
- State machine: IDLE, WAIT, SAMPLE.
  - IDLE: if NumberChecked != last-candidate, latch it, load settle counter with SETTLE, go to WAIT.
  - WAIT: decrement the counter. If NumberChecked changes again, relatch and reload the counter; stay in WAIT. At counter==1 go to SAMPLE.
  - SAMPLE: one cycle. If Prime==1, perform a capture; then return to IDLE.
- Capture:
  - FIFO not full: write the latched candidate at the write pointer; pointer wraps modulo DEPTH.
  - FIFO full and no pop this cycle: drop the value and set Overflow (stays 1 until Reset).
  - FIFO full with a pop in the same cycle: write succeeds, Count unchanged, Overflow not set.
  - Gap and LastPrime update whether the value is written or dropped.
- Gap:
  - If have-prev: gap = candidate - LastPrime, 10-bit unsigned; MaxGap = max(MaxGap, gap).
  - Then LastPrime = candidate and have-prev = 1.
- Restart detection:
  - A latched candidate lower than LastPrime means primenums restarted.
  - Clear have-prev before the gap calculation; that candidate contributes no gap.
  - MaxGap and FIFO contents are retained.
- Read side:
  - Pop when PrimeValid && PrimeReady.
  - PrimeOut is the registered head, valid the same cycle PrimeValid=1.
  - Read pointer wraps modulo DEPTH.
  - PrimeReady while empty is ignored.
- Timing:
  - Push and pop in the same cycle leave Count unchanged.
  - A pushed value becomes visible on PrimeOut/PrimeValid the cycle after SAMPLE.
  - Full and Count update on the same edge as the pointers.
- Latency from a NumberChecked change to PrimeValid rising, FIFO empty and no retrigger: SETTLE+2 cycles.
- Reset mid-WAIT or mid-SAMPLE discards the pending candidate entirely: no capture, no statistics update.

Optional Feature:
- Macro: PRIME_TWIN_COUNT_EN.
- Defined:
  - Adds output port TwinCount, 8 bits, reset 0.
  - Increments on every gap calculation where gap==2; saturates at 255.
  - Restart clears have-prev, so no twin is counted across a restart.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Drive primenums with NumMax=20 and reader always ready -> pops 2,3,5,7,11,13,17,19 in order; MaxGap=4; LastPrime=19; Overflow=0; TwinCount=4 with PRIME_TWIN_COUNT_EN.
- NumMax=30, PrimeReady=0 throughout -> Count reaches 8, Full=1 after 19; 23 and 29 dropped; Overflow=1; LastPrime=29; MaxGap=6; raise PrimeReady -> 2..19 drain, PrimeValid falls after 8 pops.
- FIFO full; pop and capture coincide in the same cycle -> Count stays 8, Overflow stays 0, new prime appears at the tail.
- Rerun primenums from 2 after reaching 13 -> candidate 2 gives no gap; MaxGap keeps 4; FIFO retains 2..13 plus the new 2.
- Assert Reset during WAIT for candidate 11 -> all outputs return to reset values immediately; 11 is never pushed.
- NumberChecked toggling every cycle with SETTLE=2 -> no SAMPLE occurs, so nothing is captured; once it holds 7 with Prime=1, exactly one push of 7.
